// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 mouse tracker.
// Optional odd-parity enforcement is selected with MOUSE_PARITY_CHK_EN.
package ps2_pkg;

   localparam int PS2_FRAME_BITS = 11;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } rx_state_e;

   typedef enum logic [1:0] {
      WAIT_B0 = 2'd0,
      WAIT_B1 = 2'd1,
      WAIT_B2 = 2'd2
   } pkt_state_e;

   typedef struct packed {
      logic [2:0] btn;
      logic       sx;
      logic       sy;
      logic       ox;
      logic       oy;
      logic [7:0] dx;
      logic [7:0] dy;
   } mouse_pkt_t;

   // Saturate a signed candidate position into [0, max].
   function automatic logic [15:0] sat_pos(input logic signed [17:0] v,
                                           input logic [15:0]        max);
      if (v < 18'sd0)
         return 16'd0;
      else if (v > $signed({2'b00, max}))
         return max;
      else
         return v[15:0];
   endfunction

endpackage

// File: rtl/ps2_rx_byte.sv
// PS/2 byte receiver: synchronizer, clock glitch filter, 11-bit frame shifter,
// frame/parity error and idle timeout. Parity check only with MOUSE_PARITY_CHK_EN.
module ps2_rx_byte
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 8000
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_ps2_clk,
   input  logic       i_ps2_data,
   input  logic       i_busy,
   output logic [7:0] o_byte,
   output logic       o_byte_valid,
   output logic       o_frame_err,
   output logic       o_parity_err,
   output logic       o_timeout
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [3:0] STOP_IDX = 4'(PS2_FRAME_BITS - 1);

   logic [1:0]    clk_sync_q, data_sync_q;
   logic          ps2_clk_s, ps2_data_s;
   logic [FW-1:0] filt_cnt_q;
   logic          filt_level_q;
   logic          filt_flip, fall;
   rx_state_e     state_q, state_d;
   logic [3:0]    bit_cnt_q;
   logic [7:0]    shift_q;
   logic [TW-1:0] tmr_q;
   logic          active, timeout_hit;
`ifdef MOUSE_PARITY_CHK_EN
   logic          parity_q;
`endif

   assign ps2_clk_s  = clk_sync_q[1];
   assign ps2_data_s = data_sync_q[1];

   // A new clock level is accepted once it has held for FILTER_LEN cycles.
   assign filt_flip = (ps2_clk_s != filt_level_q) && (filt_cnt_q == FW'(FILTER_LEN - 1));
   assign fall      = filt_flip && filt_level_q;

   assign active      = (state_q == SHIFT) || i_busy;
   assign timeout_hit = active && !fall && (tmr_q == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         clk_sync_q   <= 2'b11;
         data_sync_q  <= 2'b11;
         filt_cnt_q   <= '0;
         filt_level_q <= 1'b1;
      end else begin
         clk_sync_q  <= {clk_sync_q[0], i_ps2_clk};
         data_sync_q <= {data_sync_q[0], i_ps2_data};
         if (ps2_clk_s == filt_level_q) begin
            filt_cnt_q <= '0;
         end else if (filt_flip) begin
            filt_level_q <= ps2_clk_s;
            filt_cnt_q   <= '0;
         end else begin
            filt_cnt_q <= filt_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (fall && !ps2_data_s) state_d = SHIFT;
         SHIFT: if (timeout_hit || (fall && bit_cnt_q == STOP_IDX)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         tmr_q        <= '0;
         o_byte_valid <= 1'b0;
         o_frame_err  <= 1'b0;
         o_parity_err <= 1'b0;
         o_timeout    <= 1'b0;
`ifdef MOUSE_PARITY_CHK_EN
         parity_q     <= 1'b0;
`endif
      end else begin
         o_byte_valid <= 1'b0;
         o_frame_err  <= 1'b0;
         o_parity_err <= 1'b0;
         o_timeout    <= timeout_hit;
         if (!active || fall || timeout_hit) tmr_q <= '0;
         else                                tmr_q <= tmr_q + 1'b1;

         if (fall) begin
            if (state_q == IDLE) begin
               if (ps2_data_s) o_frame_err <= 1'b1;
               bit_cnt_q <= 4'd1;
            end else begin
               bit_cnt_q <= bit_cnt_q + 1'b1;
               if (bit_cnt_q <= 4'd8) shift_q <= {ps2_data_s, shift_q[7:1]};
`ifdef MOUSE_PARITY_CHK_EN
               if (bit_cnt_q == 4'd9) parity_q <= ps2_data_s;
`endif
               if (bit_cnt_q == STOP_IDX) begin
                  if (!ps2_data_s)
                     o_frame_err <= 1'b1;
`ifdef MOUSE_PARITY_CHK_EN
                  else if (!(^{shift_q, parity_q}))
                     o_parity_err <= 1'b1;
`endif
                  else
                     o_byte_valid <= 1'b1;
               end
            end
         end
      end
   end

   assign o_byte = shift_q;

endmodule

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse tracker: packet assembly, clamped absolute position, button state.
// Define MOUSE_PARITY_CHK_EN to drop bytes with even parity.
module ps2_mouse_tracker
   import ps2_pkg::*;
#(
   parameter int X_MAX       = 3159,
   parameter int Y_MAX       = 2363,
   parameter int X_INIT      = 1600,
   parameter int Y_INIT      = 1200,
   parameter int GAIN_SHIFT  = 0,
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 8000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_ps2_clk,
   input  logic        i_ps2_data,
   input  logic        i_recenter,
   output logic [15:0] o_mouse_x,
   output logic [15:0] o_mouse_y,
   output logic        o_mouse_left,
   output logic        o_mouse_right,
   output logic        o_mouse_middle,
   output logic        o_packet_valid,
   output logic        o_err
);

   logic [7:0]        rx_byte;
   logic              rx_valid, rx_frame_err, rx_parity_err, rx_timeout;
   pkt_state_e        pkt_state_q, pkt_state_d;
   logic              sync_err, apply;
   logic [7:0]        b0_q, b1_q;
   mouse_pkt_t        pkt;
   logic signed [17:0] dx_ext, dy_ext, x_sum, y_sum;

   ps2_rx_byte #(
      .FILTER_LEN  (FILTER_LEN),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_rx (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_ps2_clk    (i_ps2_clk),
      .i_ps2_data   (i_ps2_data),
      .i_busy       (pkt_state_q != WAIT_B0),
      .o_byte       (rx_byte),
      .o_byte_valid (rx_valid),
      .o_frame_err  (rx_frame_err),
      .o_parity_err (rx_parity_err),
      .o_timeout    (rx_timeout)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) pkt_state_q <= WAIT_B0;
      else          pkt_state_q <= pkt_state_d;
   end

   // Timeout and parity errors abandon any partial packet.
   always_comb begin
      pkt_state_d = pkt_state_q;
      sync_err    = 1'b0;
      apply       = 1'b0;
      if (rx_timeout || rx_parity_err) begin
         pkt_state_d = WAIT_B0;
      end else if (rx_valid) begin
         case (pkt_state_q)
            WAIT_B0: begin
               if (rx_byte[3]) pkt_state_d = WAIT_B1;
               else            sync_err    = 1'b1;
            end
            WAIT_B1: pkt_state_d = WAIT_B2;
            WAIT_B2: begin
               pkt_state_d = WAIT_B0;
               apply       = 1'b1;
            end
            default: pkt_state_d = WAIT_B0;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         b0_q <= '0;
         b1_q <= '0;
      end else if (rx_valid) begin
         if (pkt_state_q == WAIT_B0) b0_q <= rx_byte;
         if (pkt_state_q == WAIT_B1) b1_q <= rx_byte;
      end
   end

   // Byte 2 is still on rx_byte during the apply cycle.
   assign pkt = '{btn: b0_q[2:0], sx: b0_q[4], sy: b0_q[5], ox: b0_q[6], oy: b0_q[7],
                  dx: b1_q, dy: rx_byte};

   assign dx_ext = pkt.ox ? 18'sd0 : 18'($signed({pkt.sx, pkt.dx}));
   assign dy_ext = pkt.oy ? 18'sd0 : 18'($signed({pkt.sy, pkt.dy}));
   assign x_sum  = $signed({2'b00, o_mouse_x}) + (dx_ext <<< GAIN_SHIFT);
   assign y_sum  = $signed({2'b00, o_mouse_y}) + (dy_ext <<< GAIN_SHIFT);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_mouse_x      <= 16'(X_INIT);
         o_mouse_y      <= 16'(Y_INIT);
         o_mouse_left   <= 1'b0;
         o_mouse_right  <= 1'b0;
         o_mouse_middle <= 1'b0;
         o_packet_valid <= 1'b0;
         o_err          <= 1'b0;
      end else begin
         o_packet_valid <= apply;
         o_err          <= rx_frame_err | rx_parity_err | rx_timeout | sync_err;
         if (apply) begin
            o_mouse_left   <= pkt.btn[0];
            o_mouse_right  <= pkt.btn[1];
            o_mouse_middle <= pkt.btn[2];
         end
         if (i_recenter) begin
            o_mouse_x <= 16'(X_INIT);
            o_mouse_y <= 16'(Y_INIT);
         end else if (apply) begin
            o_mouse_x <= sat_pos(x_sum, 16'(X_MAX));
            o_mouse_y <= sat_pos(y_sum, 16'(Y_MAX));
         end
      end
   end

endmodule
